dmi_initiator: RTL and testbench

DMI_INITIATOR -- requirements
Module: dmi_initiator

---
 rtl/dm_pkg.sv | 32 +++
 rtl/dmi_initiator_if.sv | 24 ++
 rtl/dmi_initiator.sv | 125 ++++++++++++
 tb/tb_dmi_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Debug-module shared types: DTM opcodes, DMI request/response payloads, sticky status.
// Latency: n/a (types only).
// Backpressure: n/a.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DMI_SUCCESS = 2'h0,
        DMI_FAILED  = 2'h2,
        DMI_BUSY    = 2'h3
    } dmi_status_e;

    // Response code carried in dmi_resp_t.resp meaning "access succeeded".
    localparam logic [1:0] DmiRespSuccess = 2'h0;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_initiator_if.sv
// DMI request/response channel bundle between the DTM initiator and the debug module.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface dmi_initiator_if;
    import dm::*;

    logic      req_valid;
    logic      req_ready;
    dmi_req_t  req;
    logic      resp_valid;
    logic      resp_ready;
    dmi_resp_t resp;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp
    );

endinterface

// File: rtl/dmi_initiator.sv
// DTM-side DMI initiator: turns single-cycle commands into one DMI request/response exchange.
// Latency: 3 cycles cmd -> rsp_valid_o minimum (IDLE->REQ->WAIT->IDLE); NOP or dropped command 1 cycle.
// Backpressure: holds the request while req_ready is low; gives up after TimeoutCycles WAIT cycles.
module dmi_initiator
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    input  dtm_op_e         cmd_op_i,
    input  logic [6:0]      cmd_addr_i,
    input  logic [31:0]     cmd_data_i,
    input  logic            dmi_clear_i,
    output logic            busy_o,
    output logic            rsp_valid_o,
    output logic [31:0]     rsp_data_o,
    output dmi_status_e     rsp_status_o,
    output logic            dmi_rst_no,
    dmi_initiator_if.master dmi
);

    // Guard keeps the counter at least one bit wide for a degenerate zero timeout.
    localparam int unsigned   CntW   = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        REQ  = 2'h1,
        WAIT = 2'h2
    } state_e;

    state_e          state_q;
    dmi_req_t        req_q;
    logic [31:0]     rsp_data_q;
    dmi_status_e     status_q;
    logic            rsp_valid_q;
    logic            dmi_rst_n_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Saturating WAIT-cycle count; reaching CntMax on this edge means the response is lost.
    always_comb begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    // Single FSM: clear beats everything, then command acceptance, handshake, response or timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_data_q  <= '0;
            status_q    <= DMI_SUCCESS;
            rsp_valid_q <= 1'b0;
            dmi_rst_n_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            dmi_rst_n_q <= 1'b1;
            if (dmi_clear_i) begin
                status_q <= DMI_SUCCESS;
                // Abandoning an access also flushes whatever the DM may still return.
                if (state_q != IDLE) begin
                    dmi_rst_n_q <= 1'b0;
                    state_q     <= IDLE;
                end
            end else begin
                // A command while busy is lost; record it unless a failure is already sticky.
                if (state_q != IDLE && cmd_valid_i && status_q != DMI_FAILED) begin
                    status_q <= DMI_BUSY;
                end
                case (state_q)
                    IDLE: begin
                        if (cmd_valid_i) begin
                            if (status_q != DMI_SUCCESS || cmd_op_i == DTM_NOP) begin
                                rsp_valid_q <= 1'b1;
                            end else if (cmd_op_i == DTM_READ || cmd_op_i == DTM_WRITE) begin
                                req_q   <= '{addr: cmd_addr_i, op: cmd_op_i, data: cmd_data_i};
                                state_q <= REQ;
                            end
                        end
                    end
                    REQ: begin
                        if (dmi.req_ready) begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    WAIT: begin
                        // A response in the expiry cycle wins over the timeout.
                        if (dmi.resp_valid) begin
                            state_q     <= IDLE;
                            rsp_valid_q <= 1'b1;
                            if (dmi.resp.resp != DmiRespSuccess) begin
                                status_q <= DMI_FAILED;
                            end else if (req_q.op == DTM_READ) begin
                                rsp_data_q <= dmi.resp.data;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                            if (cnt_d == CntMax) begin
                                status_q    <= DMI_FAILED;
                                dmi_rst_n_q <= 1'b0;
                                state_q     <= IDLE;
                                rsp_valid_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o          = (state_q != IDLE);
    assign dmi.req_valid   = (state_q == REQ);
    assign dmi.resp_ready  = (state_q == WAIT);
    assign dmi.req         = req_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_status_o    = status_q;
    assign dmi_rst_no      = dmi_rst_n_q;

endmodule

// File: tb/tb_dmi_initiator.sv
// Bench for dmi_initiator: directed scenarios with literal expectations plus randomized traffic.
// A transaction-level model predicts every output each cycle; one process compares on negedge.
// Inputs change on negedge, the model advances on posedge, so nothing races the DUT.
module tb_dmi_initiator;
    import dm::*;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    dtm_op_e     cmd_op = DTM_NOP;
    logic [6:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        dmi_clear = 1'b0;
    logic        busy, rsp_valid, dmi_rst_n;
    logic [31:0] rsp_data;
    dmi_status_e rsp_status;

    dmi_initiator_if bus ();

    always #5 clk = ~clk;

    dmi_initiator #(.TimeoutCycles(T)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_op_i     (cmd_op),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .dmi_clear_i  (dmi_clear),
        .busy_o       (busy),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_status_o (rsp_status),
        .dmi_rst_no   (dmi_rst_n),
        .dmi          (bus.master)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction view) ----------------
    // m_ph: 0 = no access, 1 = request offered, 2 = awaiting response
    int          m_ph;
    int          m_waited;
    dmi_req_t    m_req;
    logic [31:0] m_data;
    logic [1:0]  m_status;
    bit          m_pulse;
    bit          m_flush;

    always @(posedge clk or negedge rst_n) begin : model
        int          ph, w;
        logic [1:0]  st;
        bit          p, f;
        dmi_req_t    rq;
        logic [31:0] d;
        if (!rst_n) begin
            m_ph <= 0; m_waited <= 0; m_req <= '0; m_data <= '0;
            m_status <= 2'd0; m_pulse <= 1'b0; m_flush <= 1'b0;
        end else begin
            ph = m_ph; w = m_waited; st = m_status; rq = m_req; d = m_data;
            p = 1'b0; f = 1'b0;
            if (dmi_clear) begin
                st = 2'd0;
                if (ph != 0) begin f = 1'b1; ph = 0; end
            end else if (ph == 0) begin
                if (cmd_valid) begin
                    if (st != 2'd0 || cmd_op == DTM_NOP) p = 1'b1;
                    else if (cmd_op == DTM_READ || cmd_op == DTM_WRITE) begin
                        rq = '{addr: cmd_addr, op: cmd_op, data: cmd_data};
                        ph = 1;
                    end
                end
            end else begin
                if (cmd_valid && st != 2'd2) st = 2'd3;
                if (ph == 1) begin
                    if (bus.req_ready) begin ph = 2; w = 0; end
                end else if (bus.resp_valid) begin
                    p = 1'b1; ph = 0;
                    if (bus.resp.resp != 2'd0) st = 2'd2;
                    else if (rq.op == DTM_READ) d = bus.resp.data;
                end else begin
                    w = w + 1;
                    if (w >= int'(T)) begin st = 2'd2; f = 1'b1; p = 1'b1; ph = 0; end
                end
            end
            m_ph <= ph; m_waited <= w; m_status <= st; m_req <= rq; m_data <= d;
            m_pulse <= p; m_flush <= f;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy",       64'(busy),           64'(m_ph != 0));
            chk("m_req_valid",  64'(bus.req_valid),  64'(m_ph == 1));
            chk("m_resp_ready", 64'(bus.resp_ready), 64'(m_ph == 2));
            chk("m_rsp_valid",  64'(rsp_valid),      64'(m_pulse));
            chk("m_rsp_data",   64'(rsp_data),       64'(m_data));
            chk("m_rsp_status", 64'(rsp_status),     64'(m_status));
            chk("m_dmi_rst_n",  64'(dmi_rst_n),      64'(!m_flush));
            chk("m_dmi_req",    64'(bus.req),        64'(m_req));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        cmd_valid = 1'b0; dmi_clear = 1'b0; bus.resp_valid = 1'b0;
    endtask

    task automatic issue(input dtm_op_e op, input logic [6:0] a, input logic [31:0] dt);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = dt;
    endtask

    task automatic respond(input logic [31:0] dt, input logic [1:0] rc);
        bus.resp_valid = 1'b1; bus.resp = '{data: dt, resp: rc};
    endtask

    task automatic do_clear();
        dmi_clear = 1'b1; tick(); dmi_clear = 1'b0;
    endtask

    dmi_req_t exp_w;
    int       rpct, qpct;

    initial begin
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp = '0;
        repeat (2) tick();
        // reset values
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_resp_ready", 64'(bus.resp_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_dmi_rst_n", 64'(dmi_rst_n), 64'd1);
        chk("rst_req", 64'(bus.req), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        chk("rst_status", 64'(rsp_status), 64'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // READ 0x11, response one cycle after the handshake
        bus.req_ready = 1'b1;
        issue(DTM_READ, 7'h11, 32'h0);
        tick(); cmd_valid = 1'b0;
        chk("rd_req_valid", 64'(bus.req_valid), 64'd1);
        chk("rd_req_addr", 64'(bus.req.addr), 64'h11);
        chk("rd_rsp_early1", 64'(rsp_valid), 64'd0);
        tick();
        chk("rd_resp_ready", 64'(bus.resp_ready), 64'd1);
        chk("rd_rsp_early2", 64'(rsp_valid), 64'd0);
        respond(32'hDEADBEEF, 2'd0);
        tick(); bus.resp_valid = 1'b0;
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        chk("rd_status", 64'(rsp_status), 64'd0);
        chk("rd_busy", 64'(busy), 64'd0);
        tick();
        chk("rd_pulse_end", 64'(rsp_valid), 64'd0);

        // WRITE 0x10 with ready held low for 5 cycles
        bus.req_ready = 1'b0;
        issue(DTM_WRITE, 7'h10, 32'h1);
        exp_w = '{addr: 7'h10, op: DTM_WRITE, data: 32'h1};
        tick(); cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold_valid", 64'(bus.req_valid), 64'd1);
            chk("wr_hold_req", 64'(bus.req), 64'(exp_w));
            tick();
        end
        bus.req_ready = 1'b1;
        tick(); bus.req_ready = 1'b0;
        chk("wr_after_hs_valid", 64'(bus.req_valid), 64'd0);
        chk("wr_after_hs_wait", 64'(bus.resp_ready), 64'd1);
        respond(32'h55, 2'd0);
        tick(); bus.resp_valid = 1'b0;
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_data_kept", 64'(rsp_data), 64'hDEADBEEF);
        tick();
        chk("wr_single_hs", 64'(bus.req_valid), 64'd0);

        // second command while waiting -> BUSY, sticky until clear
        bus.req_ready = 1'b1;
        issue(DTM_READ, 7'h20, 32'h0);
        tick(); cmd_valid = 1'b0;
        tick();
        issue(DTM_WRITE, 7'h21, 32'h7);
        tick(); cmd_valid = 1'b0;
        chk("busy_still_wait", 64'(busy), 64'd1);
        chk("busy_status", 64'(rsp_status), 64'd3);
        respond(32'h12345678, 2'd0);
        tick(); bus.resp_valid = 1'b0;
        chk("busy_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("busy_rsp_data", 64'(rsp_data), 64'h12345678);
        chk("busy_status2", 64'(rsp_status), 64'd3);
        issue(DTM_READ, 7'h22, 32'h0);
        tick(); cmd_valid = 1'b0;
        chk("drop_pulse", 64'(rsp_valid), 64'd1);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_status", 64'(rsp_status), 64'd3);
        tick();
        chk("drop_no_req", 64'(bus.req_valid), 64'd0);
        do_clear();
        chk("clr_status", 64'(rsp_status), 64'd0);
        chk("clr_idle_no_flush", 64'(dmi_rst_n), 64'd1);

        // failed response
        issue(DTM_READ, 7'h30, 32'h0);
        tick(); cmd_valid = 1'b0;
        tick();
        respond(32'hCAFEF00D, 2'd2);
        tick(); bus.resp_valid = 1'b0;
        chk("fail_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("fail_status", 64'(rsp_status), 64'd2);
        chk("fail_data_kept", 64'(rsp_data), 64'h12345678);
        do_clear();

        // timeout: no response for T WAIT cycles
        issue(DTM_READ, 7'h31, 32'h0);
        tick(); cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < int'(T); i++) begin
            chk("to_waiting", 64'(busy), 64'd1);
            chk("to_no_flush", 64'(dmi_rst_n), 64'd1);
            tick();
        end
        chk("to_flush", 64'(dmi_rst_n), 64'd0);
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to_status", 64'(rsp_status), 64'd2);
        chk("to_busy", 64'(busy), 64'd0);
        tick();
        chk("to_flush_end", 64'(dmi_rst_n), 64'd1);
        do_clear();

        // response in the expiry cycle is taken as the response
        issue(DTM_READ, 7'h32, 32'h0);
        tick(); cmd_valid = 1'b0;
        repeat (T) tick();
        respond(32'h0BADF00D, 2'd0);
        tick(); bus.resp_valid = 1'b0;
        chk("edge_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("edge_no_flush", 64'(dmi_rst_n), 64'd1);
        chk("edge_status", 64'(rsp_status), 64'd0);
        chk("edge_data", 64'(rsp_data), 64'h0BADF00D);

        // clear and response in the same WAIT cycle
        issue(DTM_READ, 7'h33, 32'h0);
        tick(); cmd_valid = 1'b0;
        tick();
        dmi_clear = 1'b1;
        respond(32'hAAAA5555, 2'd0);
        tick(); quiet();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
        chk("abort_flush", 64'(dmi_rst_n), 64'd0);
        chk("abort_status", 64'(rsp_status), 64'd0);
        chk("abort_data", 64'(rsp_data), 64'h0BADF00D);
        tick();
        chk("abort_no_rsp2", 64'(rsp_valid), 64'd0);

        // asynchronous reset in the middle of REQ
        bus.req_ready = 1'b0;
        issue(DTM_WRITE, 7'h34, 32'h99);
        tick(); cmd_valid = 1'b0;
        chk("mid_req_valid", 64'(bus.req_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("arst_resp_ready", 64'(bus.resp_ready), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_dmi_rst_n", 64'(dmi_rst_n), 64'd1);
        chk("arst_req", 64'(bus.req), 64'd0);
        chk("arst_data", 64'(rsp_data), 64'd0);
        chk("arst_status", 64'(rsp_status), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic in segments with varying slave behaviour
        for (int seg = 0; seg < 16; seg++) begin
            rpct = (seg % 4 == 0) ? 0 : int'($urandom_range(10, 60));
            qpct = int'($urandom_range(20, 90));
            for (int c = 0; c < 200; c++) begin
                cmd_valid     = ($urandom_range(0, 99) < 20);
                cmd_op        = dtm_op_e'($urandom_range(0, 2));
                cmd_addr      = 7'($urandom);
                cmd_data      = $urandom;
                dmi_clear     = ($urandom_range(0, 99) < 3);
                bus.req_ready = ($urandom_range(0, 99) < qpct);
                bus.resp_valid = ($urandom_range(0, 99) < rpct);
                bus.resp.data = $urandom;
                bus.resp.resp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                tick();
            end
        end
        quiet();
        repeat (3) tick();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
